// File: rtl/l1_l2_arbiter.sv
// Arbiter sharing the single L1->L2 request port between the L1I miss path and the L1D miss/write-back path.
// Optional feature: define ARB_RR_EN for round-robin conflict resolution (default: L1D has fixed priority).
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int BIT_WIDTH_low = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read_I_L2,
    input  logic [ADDR_WIDTH-1:0]    addr_I_L2,
    output logic                     ready_L2_I,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_I,
    input  logic                     read_D_L2,
    input  logic                     write_D_L2,
    input  logic [ADDR_WIDTH-1:0]    addr_D_L2,
    input  logic [BIT_WIDTH_low-1:0] write_data_D_L2,
    output logic                     ready_L2_D,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_D,
    output logic                     read_L1_L2,
    output logic                     write_L1_L2,
    output logic [ADDR_WIDTH-1:0]    addr_L1_L2,
    output logic [BIT_WIDTH_low-1:0] write_data_L1_L2,
    input  logic                     ready_L2_L1,
    input  logic [BIT_WIDTH_low-1:0] read_data_L2_L1,
    output logic [1:0]               grant
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    // last_grant: 0 = L1I, 1 = L1D
    logic                     last_grant, last_grant_next;
    logic                     ready_i_next, ready_d_next;
    logic                     read_next, write_next;
    logic [ADDR_WIDTH-1:0]    addr_next;
    logic [BIT_WIDTH_low-1:0] wdata_next;
    logic [BIT_WIDTH_low-1:0] rdata_i_next, rdata_d_next;
    logic [1:0]               grant_next;
    logic                     i_req, d_req, pick_d;

    assign i_req = read_I_L2;
    assign d_req = read_D_L2 | write_D_L2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        ready_i_next    = 1'b0;
        ready_d_next    = 1'b0;
        read_next       = read_L1_L2;
        write_next      = write_L1_L2;
        addr_next       = addr_L1_L2;
        wdata_next      = write_data_L1_L2;
        rdata_i_next    = read_data_L2_I;
        rdata_d_next    = read_data_L2_D;
        grant_next      = grant;
        pick_d          = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && i_req) begin
`ifdef ARB_RR_EN
                    pick_d = ~last_grant;
`else
                    pick_d = 1'b1;
`endif
                end else begin
                    pick_d = d_req;
                end

                if (i_req || d_req) begin
                    state_next = BUSY;
                    if (pick_d) begin
                        // A simultaneous read and write from L1D is treated as a write-back.
                        write_next      = write_D_L2;
                        read_next       = ~write_D_L2;
                        addr_next       = addr_D_L2;
                        wdata_next      = write_D_L2 ? write_data_D_L2 : '0;
                        grant_next      = 2'b10;
                        last_grant_next = 1'b1;
                    end else begin
                        write_next      = 1'b0;
                        read_next       = 1'b1;
                        addr_next       = addr_I_L2;
                        wdata_next      = '0;
                        grant_next      = 2'b01;
                        last_grant_next = 1'b0;
                    end
                end
            end

            BUSY: begin
                if (ready_L2_L1) begin
                    state_next = DONE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    if (grant[1]) begin
                        ready_d_next = 1'b1;
                        if (read_L1_L2) rdata_d_next = read_data_L2_L1;
                    end else begin
                        ready_i_next = 1'b1;
                        if (read_L1_L2) rdata_i_next = read_data_L2_L1;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant       <= 1'b0;
            ready_L2_I       <= 1'b0;
            ready_L2_D       <= 1'b0;
            read_L1_L2       <= 1'b0;
            write_L1_L2      <= 1'b0;
            addr_L1_L2       <= '0;
            write_data_L1_L2 <= '0;
            read_data_L2_I   <= '0;
            read_data_L2_D   <= '0;
            grant            <= 2'b00;
        end else begin
            last_grant       <= last_grant_next;
            ready_L2_I       <= ready_i_next;
            ready_L2_D       <= ready_d_next;
            read_L1_L2       <= read_next;
            write_L1_L2      <= write_next;
            addr_L1_L2       <= addr_next;
            write_data_L1_L2 <= wdata_next;
            read_data_L2_I   <= rdata_i_next;
            read_data_L2_D   <= rdata_d_next;
            grant            <= grant_next;
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed testbench for l1_l2_arbiter; expectations are hand-computed per scenario.
module tb_l1_l2_arbiter;

    localparam int AW = 32;
    localparam int DW = 512;

    logic          clk;
    logic          rst;
    logic          read_I_L2;
    logic [AW-1:0] addr_I_L2;
    logic          ready_L2_I;
    logic [DW-1:0] read_data_L2_I;
    logic          read_D_L2;
    logic          write_D_L2;
    logic [AW-1:0] addr_D_L2;
    logic [DW-1:0] write_data_D_L2;
    logic          ready_L2_D;
    logic [DW-1:0] read_data_L2_D;
    logic          read_L1_L2;
    logic          write_L1_L2;
    logic [AW-1:0] addr_L1_L2;
    logic [DW-1:0] write_data_L1_L2;
    logic          ready_L2_L1;
    logic [DW-1:0] read_data_L2_L1;
    logic [1:0]    grant;

    int vectors;
    int miscompares;
    logic [DW-1:0] exp_rd_i;
    logic [DW-1:0] exp_rd_d;

    l1_l2_arbiter #(.ADDR_WIDTH(AW), .BIT_WIDTH_low(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .read_I_L2        (read_I_L2),
        .addr_I_L2        (addr_I_L2),
        .ready_L2_I       (ready_L2_I),
        .read_data_L2_I   (read_data_L2_I),
        .read_D_L2        (read_D_L2),
        .write_D_L2       (write_D_L2),
        .addr_D_L2        (addr_D_L2),
        .write_data_D_L2  (write_data_D_L2),
        .ready_L2_D       (ready_L2_D),
        .read_data_L2_D   (read_data_L2_D),
        .read_L1_L2       (read_L1_L2),
        .write_L1_L2      (write_L1_L2),
        .addr_L1_L2       (addr_L1_L2),
        .write_data_L1_L2 (write_data_L1_L2),
        .ready_L2_L1      (ready_L2_L1),
        .read_data_L2_L1  (read_data_L2_L1),
        .grant            (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        read_I_L2       = 1'b0;
        addr_I_L2       = '0;
        read_D_L2       = 1'b0;
        write_D_L2      = 1'b0;
        addr_D_L2       = '0;
        write_data_D_L2 = '0;
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_rd_i = '0;
        exp_rd_d = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
        vectors++;
        if ({read_L1_L2, write_L1_L2, ready_L2_I, ready_L2_D} !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {read_L1_L2, write_L1_L2, ready_L2_I, ready_L2_D});
        end
        vectors++;
        if (addr_L1_L2 !== '0 || write_data_L1_L2 !== '0) begin
            miscompares++; $display("[TB] FAIL reset_addr_data: got addr %0h wdata %0h expected 0", addr_L1_L2, write_data_L1_L2);
        end
        vectors++;
        if (read_data_L2_I !== '0 || read_data_L2_D !== '0) begin
            miscompares++; $display("[TB] FAIL reset_rdata: got I %0h D %0h expected 0", read_data_L2_I, read_data_L2_D);
        end
    endtask

    task automatic test_i_read();
        read_I_L2 = 1'b1;
        addr_I_L2 = 32'h000100C0;
        step();
        vectors++;
        if (read_L1_L2 !== 1'b1 || write_L1_L2 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL iread_req: got rd %b wr %b expected rd 1 wr 0", read_L1_L2, write_L1_L2);
        end
        vectors++;
        if (addr_L1_L2 !== 32'h000100C0) begin miscompares++; $display("[TB] FAIL iread_addr: got %0h expected 100c0", addr_L1_L2); end
        vectors++;
        if (grant !== 2'b01) begin miscompares++; $display("[TB] FAIL iread_grant: got %b expected 01", grant); end
        repeat (4) step();
        vectors++;
        if (ready_L2_I !== 1'b0 || read_L1_L2 !== 1'b1) begin
            miscompares++; $display("[TB] FAIL iread_busy_hold: got rdy %b rd %b expected rdy 0 rd 1", ready_L2_I, read_L1_L2);
        end
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'hA5}};
        step();
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        read_I_L2       = 1'b0;
        exp_rd_i        = {64{8'hA5}};
        vectors++;
        if (ready_L2_I !== 1'b1 || ready_L2_D !== 1'b0) begin
            miscompares++; $display("[TB] FAIL iread_ready: got I %b D %b expected I 1 D 0", ready_L2_I, ready_L2_D);
        end
        vectors++;
        if (read_data_L2_I !== exp_rd_i) begin miscompares++; $display("[TB] FAIL iread_data: got %0h expected %0h", read_data_L2_I, exp_rd_i); end
        vectors++;
        if (read_L1_L2 !== 1'b0 || grant !== 2'b01) begin
            miscompares++; $display("[TB] FAIL iread_done: got rd %b grant %b expected rd 0 grant 01", read_L1_L2, grant);
        end
        step();
        vectors++;
        if (ready_L2_I !== 1'b0 || grant !== 2'b00 || read_data_L2_I !== exp_rd_i) begin
            miscompares++; $display("[TB] FAIL iread_idle: got rdy %b grant %b data %0h expected 0 00 hold", ready_L2_I, grant, read_data_L2_I);
        end
    endtask

    task automatic test_d_write();
        logic [DW-1:0] wd;
        wd              = {16{32'h12345678}};
        write_D_L2      = 1'b1;
        addr_D_L2       = 32'h00020040;
        write_data_D_L2 = wd;
        step();
        vectors++;
        if (write_L1_L2 !== 1'b1 || read_L1_L2 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL dwr_req: got rd %b wr %b expected rd 0 wr 1", read_L1_L2, write_L1_L2);
        end
        vectors++;
        if (addr_L1_L2 !== 32'h00020040 || write_data_L1_L2 !== wd) begin
            miscompares++; $display("[TB] FAIL dwr_addr_data: got addr %0h data %0h expected 20040 %0h", addr_L1_L2, write_data_L1_L2, wd);
        end
        vectors++;
        if (grant !== 2'b10) begin miscompares++; $display("[TB] FAIL dwr_grant: got %b expected 10", grant); end
        repeat (2) step();
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'h3C}};
        step();
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        write_D_L2      = 1'b0;
        vectors++;
        if (ready_L2_D !== 1'b1 || ready_L2_I !== 1'b0 || write_L1_L2 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL dwr_ready: got D %b I %b wr %b expected 1 0 0", ready_L2_D, ready_L2_I, write_L1_L2);
        end
        vectors++;
        if (read_data_L2_D !== exp_rd_d) begin miscompares++; $display("[TB] FAIL dwr_rdata_hold: got %0h expected %0h", read_data_L2_D, exp_rd_d); end
        step();
        vectors++;
        if (ready_L2_D !== 1'b0 || grant !== 2'b00) begin
            miscompares++; $display("[TB] FAIL dwr_idle: got rdy %b grant %b expected 0 00", ready_L2_D, grant);
        end
    endtask

    task automatic test_conflict_handoff();
        clear_inputs();
        do_reset();
        read_I_L2 = 1'b1;
        addr_I_L2 = 32'h000300C0;
        read_D_L2 = 1'b1;
        addr_D_L2 = 32'h00040080;
        step();
        vectors++;
        if (grant !== 2'b10 || addr_L1_L2 !== 32'h00040080) begin
            miscompares++; $display("[TB] FAIL conf_first: got grant %b addr %0h expected 10 40080", grant, addr_L1_L2);
        end
        step();
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'h5A}};
        step();
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        read_D_L2       = 1'b0;
        exp_rd_d        = {64{8'h5A}};
        vectors++;
        if (ready_L2_D !== 1'b1 || ready_L2_I !== 1'b0 || read_data_L2_D !== exp_rd_d) begin
            miscompares++; $display("[TB] FAIL conf_d_done: got D %b I %b data %0h expected 1 0 %0h", ready_L2_D, ready_L2_I, read_data_L2_D, exp_rd_d);
        end
        step();
        vectors++;
        if (grant !== 2'b00 || read_L1_L2 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL conf_turnaround_u2: got grant %b rd %b expected 00 0", grant, read_L1_L2);
        end
        step();
        vectors++;
        if (grant !== 2'b01 || read_L1_L2 !== 1'b1 || addr_L1_L2 !== 32'h000300C0) begin
            miscompares++; $display("[TB] FAIL conf_second_u3: got grant %b rd %b addr %0h expected 01 1 300c0", grant, read_L1_L2, addr_L1_L2);
        end
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'hC3}};
        step();
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        read_I_L2       = 1'b0;
        exp_rd_i        = {64{8'hC3}};
        vectors++;
        if (ready_L2_I !== 1'b1 || read_data_L2_I !== exp_rd_i || read_data_L2_D !== exp_rd_d) begin
            miscompares++; $display("[TB] FAIL conf_i_done: got rdy %b I %0h D %0h", ready_L2_I, read_data_L2_I, read_data_L2_D);
        end
        step();
    endtask

    task automatic test_rr_sequence();
        logic [1:0] exp_grant;
        clear_inputs();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            read_I_L2 = 1'b1;
            addr_I_L2 = 32'h00001000 + 32'(k * 64);
            read_D_L2 = 1'b1;
            addr_D_L2 = 32'h00002000 + 32'(k * 64);
`ifdef ARB_RR_EN
            exp_grant = (k == 1) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b10;
`endif
            step();
            vectors++;
            if (grant !== exp_grant) begin
                miscompares++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, grant, exp_grant);
            end
            ready_L2_L1     = 1'b1;
            read_data_L2_L1 = {64{8'h10 + 8'(k)}};
            step();
            clear_inputs();
            vectors++;
            if ({ready_L2_D, ready_L2_I} !== exp_grant) begin
                miscompares++; $display("[TB] FAIL rr_ready_%0d: got %b expected %b", k, {ready_L2_D, ready_L2_I}, exp_grant);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_busy();
        read_I_L2 = 1'b1;
        addr_I_L2 = 32'h00007700;
        step();
        vectors++;
        if (read_L1_L2 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy_pre: got rd %b expected 1", read_L1_L2); end
        rst = 1'b1;
        step();
        rst       = 1'b0;
        read_I_L2 = 1'b0;
        exp_rd_i  = '0;
        exp_rd_d  = '0;
        vectors++;
        if ({read_L1_L2, write_L1_L2, ready_L2_I, ready_L2_D, grant} !== 6'b0 || addr_L1_L2 !== '0) begin
            miscompares++; $display("[TB] FAIL rst_busy_outputs: got ctrl %b addr %0h expected 0", {read_L1_L2, write_L1_L2, ready_L2_I, ready_L2_D, grant}, addr_L1_L2);
        end
        vectors++;
        if (read_data_L2_I !== '0 || read_data_L2_D !== '0) begin
            miscompares++; $display("[TB] FAIL rst_busy_rdata: got I %0h D %0h expected 0", read_data_L2_I, read_data_L2_D);
        end
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'hFF}};
        step();
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        vectors++;
        if (ready_L2_I !== 1'b0 || ready_L2_D !== 1'b0 || read_data_L2_I !== exp_rd_i) begin
            miscompares++; $display("[TB] FAIL rst_late_ready: got I %b D %b data %0h expected 0 0 0", ready_L2_I, ready_L2_D, read_data_L2_I);
        end
        step();
        vectors++;
        if (ready_L2_I !== 1'b0 || grant !== 2'b00) begin
            miscompares++; $display("[TB] FAIL rst_late_idle: got rdy %b grant %b expected 0 00", ready_L2_I, grant);
        end
    endtask

    task automatic test_rw_both_and_stray();
        logic [DW-1:0] wd;
        wd              = {8{64'hDEADBEEF_CAFEF00D}};
        read_D_L2       = 1'b1;
        write_D_L2      = 1'b1;
        addr_D_L2       = 32'h00050000;
        write_data_D_L2 = wd;
        step();
        vectors++;
        if (write_L1_L2 !== 1'b1 || read_L1_L2 !== 1'b0 || write_data_L1_L2 !== wd) begin
            miscompares++; $display("[TB] FAIL rw_both_req: got rd %b wr %b data %0h expected 0 1 %0h", read_L1_L2, write_L1_L2, write_data_L1_L2, wd);
        end
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'h77}};
        step();
        clear_inputs();
        vectors++;
        if (ready_L2_D !== 1'b1 || read_data_L2_D !== exp_rd_d) begin
            miscompares++; $display("[TB] FAIL rw_both_done: got rdy %b data %0h expected 1 %0h", ready_L2_D, read_data_L2_D, exp_rd_d);
        end
        step();
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = {64{8'hEE}};
        step();
        clear_inputs();
        step();
        vectors++;
        if (ready_L2_I !== 1'b0 || ready_L2_D !== 1'b0 || grant !== 2'b00) begin
            miscompares++; $display("[TB] FAIL stray_ready: got I %b D %b grant %b expected 0 0 00", ready_L2_I, ready_L2_D, grant);
        end
        vectors++;
        if (read_data_L2_I !== exp_rd_i || read_data_L2_D !== exp_rd_d) begin
            miscompares++; $display("[TB] FAIL stray_rdata: got I %0h D %0h expected unchanged", read_data_L2_I, read_data_L2_D);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        exp_rd_i    = '0;
        exp_rd_d    = '0;
        clear_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_conflict_handoff();
        test_rr_sequence();
        test_reset_mid_busy();
        test_rw_both_and_stray();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L1→L2 request port of the cache hierarchy between the L1I miss path and the L1D miss/write-back path.
- Accepts level-held miss requests from both L1 controllers and grants one at a time.
- Drives the L2 read/write request with a latched address and line, and routes the L2 response line and a one-cycle ready pulse back to the granted requester.
- Sits inside the cache top, between the L1I/L1D controllers and the L2 controller, on the memory clock domain.

Parameters:
- ADDR_WIDTH, 32, byte-address width of requests.
- BIT_WIDTH_low, 512, cache line width in bits.

Ports:
- clk  in  1  memory-side clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- read_I_L2  in  1  L1I line-fill request, held until ready_L2_I.
- addr_I_L2  in  ADDR_WIDTH  L1I miss line address.
- ready_L2_I  out  1  one-cycle completion pulse to L1I.
- read_data_L2_I  out  BIT_WIDTH_low  fill line to L1I.
- read_D_L2  in  1  L1D line-fill request, held until ready_L2_D.
- write_D_L2  in  1  L1D write-back request, held until ready_L2_D.
- addr_D_L2  in  ADDR_WIDTH  L1D line address.
- write_data_D_L2  in  BIT_WIDTH_low  L1D victim line.
- ready_L2_D  out  1  one-cycle completion pulse to L1D.
- read_data_L2_D  out  BIT_WIDTH_low  fill line to L1D.
- read_L1_L2  out  1  read request to L2.
- write_L1_L2  out  1  write request to L2.
- addr_L1_L2  out  ADDR_WIDTH  address to L2.
- write_data_L1_L2  out  BIT_WIDTH_low  write line to L2.
- ready_L2_L1  in  1  L2 completion pulse.
- read_data_L2_L1  in  BIT_WIDTH_low  L2 read line, valid while ready_L2_L1 is high.
- grant  out  2  one-hot current owner: [0]=L1I, [1]=L1D; 0 when idle.

Behaviour:
- Reset (synchronous, any state):
  - All outputs go to 0, including both read_data registers.
  - State goes to IDLE; last_grant goes to I.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - D request = read_D_L2 | write_D_L2. If both read_D_L2 and write_D_L2 are high, the operation is a write.
  - With no request, stay in IDLE.
  - With one requester active, grant it. With both active, apply the priority rule (L1D wins unless ARB_RR_EN).
  - At the grant edge, latch op, addr, wdata (wdata for writes only; 0 for I), then:
    - set read_L1_L2/write_L1_L2;
    - set grant;
    - update last_grant;
    - go to BUSY.
  - Latency: request high at cycle t → L2 request visible at t+1.
- BUSY:
  - Downstream outputs are held constant.
  - Requester inputs are ignored, including the non-granted side and the granted side's changes.
  - ready_L2_L1=1 at cycle u triggers, at edge u→u+1:
    - read_L1_L2/write_L1_L2 cleared;
    - for reads, read_data_L2_L1 captured into the granted side's read_data register;
    - the granted side's ready pulsed;
    - state→DONE.
  - Writes return a ready pulse but leave read_data_L2_D unchanged.
- DONE:
  - Exactly one cycle: ready_L2_I or ready_L2_D = 1; grant is still valid.
  - Requests are not sampled.
  - Next state is IDLE, with ready and grant cleared.
  - Requesters must drop their request while ready is high. A request still high in IDLE is treated as a new request.
- ready_L2_L1 in IDLE or DONE: ignored, no data capture.
- read_data_L2_I/D hold their value until that side's next read completion.
- Minimum turnaround: L2 ready at u → next L2 request earliest at u+3.
- Mid-transaction reset: transaction aborted; no ready pulse; downstream request dropped at the reset edge.
- No timeout. The arbiter waits in BUSY indefinitely for ready_L2_L1.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. On a simultaneous I and D request in IDLE, grant the side not equal to last_grant. Since reset sets last_grant=I, D wins the first conflict.
- Undefined: fixed priority, L1D always wins conflicts. last_grant is still maintained but unused.

Test Plan:
- I-only read, addr 0x100C0, L2 ready after 5 cycles with line 0xA5..A5 → read_L1_L2=1 and addr_L1_L2=0x100C0 one cycle after request; grant=01; ready_L2_I single pulse; read_data_L2_I=0xA5..A5; ready_L2_D stays 0.
- D write-back, addr 0x20040, data 0x1234..., ready_L2_L1 after 3 cycles → write_L1_L2=1 with matching addr/data; ready_L2_D pulse; read_data_L2_D unchanged.
- I and D read asserted in the same cycle, fixed priority → D granted first (grant=10). After D's DONE, I is granted in the next IDLE cycle. Check ordering and the u+3 turnaround.
- Same as above with ARB_RR_EN and three consecutive conflicts → grant order D, I, D.
- rst asserted while in BUSY → next cycle all outputs 0 and state IDLE; no ready pulse; a late ready_L2_L1 is ignored.
- read_D_L2 and write_D_L2 both high → write_L1_L2=1, read_L1_L2=0. Stray ready_L2_L1 in IDLE → no ready pulse, data registers unchanged.
